// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory arbiter slice.
package data_mem_pkg;

  typedef enum logic [1:0] {
    WE_NONE = 2'b00,
    WE_WORD = 2'b01,
    WE_HALF = 2'b10,
    WE_BYTE = 2'b11
  } mem_we_e;

  localparam logic [31:0] ADDR_LIMIT_DEFAULT = 32'h0002_0000;

  // Bytes touched by an access; a read always fetches a full word.
  function automatic logic [2:0] access_bytes(mem_we_e we);
    logic [2:0] n;
    unique case (we)
      WE_HALF: n = 3'd2;
      WE_BYTE: n = 3'd1;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_req_check.sv
// Combinational legality check for one memory request: alignment and range.
module mem_req_check
  import data_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input  logic [1:0]  we,
  input  logic [31:0] addr,
  output logic        err
);

  mem_we_e     we_e;
  logic        misaligned;
  logic [32:0] end_addr;

  always_comb begin
    we_e = mem_we_e'(we);
    unique case (we_e)
      WE_WORD: misaligned = (addr[1:0] != 2'b00);
      WE_HALF: misaligned = addr[0];
      default: misaligned = 1'b0;
    endcase
    // One extra bit so addresses near 2^32 cannot wrap under the limit
    end_addr = {1'b0, addr} + {30'd0, access_bytes(we_e)};
    err      = misaligned || (end_addr > {1'b0, ADDR_LIMIT});
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of data_mem: port 0 priority, bounded wait for port 1,
// illegal writes blocked, one-cycle registered response per accepted request.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic [31:0] ADDR_LIMIT   = ADDR_LIMIT_DEFAULT,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic [1:0]            p0_we,
  input  logic [31:0]           p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_rsp_valid,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
  output logic                  p0_rsp_err,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic [1:0]            p1_we,
  input  logic [31:0]           p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_rsp_valid,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
  output logic                  p1_rsp_err,
  output logic [1:0]            mem_we,
  output logic [31:0]           mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic [3:0]            wait_q, wait_d;
  logic                  err0, err1, sel_err;
  logic                  grant0, grant1;
  logic                  rsp0_valid_q, rsp1_valid_q, rsp0_err_q, rsp1_err_q;
  logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp1_rdata_q;

  mem_req_check #(.ADDR_LIMIT(ADDR_LIMIT)) u_check0 (
    .we  (p0_we),
    .addr(p0_addr),
    .err (err0)
  );

  mem_req_check #(.ADDR_LIMIT(ADDR_LIMIT)) u_check1 (
    .we  (p1_we),
    .addr(p1_addr),
    .err (err1)
  );

  // Grants are gated by reset so nothing is accepted or written while held in reset
  always_comb begin
    grant1 = rst_n && p1_valid && (!p0_valid || (wait_q == StarveMax));
    grant0 = rst_n && p0_valid && !grant1;
    if (!p1_valid || grant1) begin
      wait_d = 4'd0;
    end else if (wait_q < StarveMax) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  always_comb begin
    sel_err = grant1 ? err1 : err0;
    mem_we  = WE_NONE;
    mem_a   = '0;
    mem_wd  = '0;
    if (grant0 || grant1) begin
      mem_wd = grant1 ? p1_wdata : p0_wdata;
      if (!sel_err) begin
        mem_we = grant1 ? p1_we : p0_we;
        mem_a  = grant1 ? p1_addr : p0_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q       <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp0_err_q   <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_rdata_q <= '0;
      rsp1_err_q   <= 1'b0;
    end else begin
      wait_q       <= wait_d;
      rsp0_valid_q <= grant0;
      rsp1_valid_q <= grant1;
      if (grant0) begin
        rsp0_rdata_q <= err0 ? '0 : mem_rd;
        rsp0_err_q   <= err0;
      end
      if (grant1) begin
        rsp1_rdata_q <= err1 ? '0 : mem_rd;
        rsp1_err_q   <= err1;
      end
    end
  end

  assign p0_ready     = grant0;
  assign p1_ready     = grant1;
  assign p0_rsp_valid = rsp0_valid_q;
  assign p0_rsp_rdata = rsp0_rdata_q;
  assign p0_rsp_err   = rsp0_err_q;
  assign p1_rsp_valid = rsp1_valid_q;
  assign p1_rsp_rdata = rsp1_rdata_q;
  assign p1_rsp_err   = rsp1_err_q;

endmodule
